// File: rtl/pb_conditioner_if.sv
// pb_conditioner_if
//   Bundles the push-button pins and the conditioned outputs of pb_conditioner.
//   Signals:
//     pbl_raw, pbr_raw : raw left/right button pins, asynchronous, 1 = pressed
//     pbl, pbr         : single-cycle press pulses towards the game core
//     held             : debounced button level {right,left}, 1 = held
//   Modports:
//     master : the button side (drives the raw pins, observes the results)
//     slave  : the conditioner (samples the raw pins, drives pulses and held)
interface pb_conditioner_if;
    logic       pbl_raw;
    logic       pbr_raw;
    logic       pbl;
    logic       pbr;
    logic [1:0] held;

    modport master (
        output pbl_raw,
        output pbr_raw,
        input  pbl,
        input  pbr,
        input  held
    );

    modport slave (
        input  pbl_raw,
        input  pbr_raw,
        output pbl,
        output pbr,
        output held
    );
endinterface

// File: rtl/pb_conditioner.sv
// pb_conditioner
//   Input stage for the tug-of-war game. Each raw push-button pin passes through a
//   2-FF synchronizer, a debounce FSM with a stable-cycle counter and a one-shot, so
//   every physical press yields exactly one CLK_I-wide pulse regardless of bounce or
//   hold time. Left and right channels are identical and fully independent.
//   Ports:
//     CLK_I : system clock, all state on its rising edge
//     rst   : asynchronous, active-high reset
//     bus   : pb_conditioner_if.slave (pbl_raw/pbr_raw in, pbl/pbr/held out)
//   Parameters:
//     DEBOUNCE_CYCLES : stable cycles needed to accept a press or a release (>=1)
//     CNT_W           : debounce counter width, must hold DEBOUNCE_CYCLES-1
module pb_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic              CLK_I,
    input  logic              rst,
    pb_conditioner_if.slave   bus
);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw_vec;
    logic [1:0] pulse_vec;
    logic [1:0] held_vec;

    // Index 0 = left, index 1 = right, matching the {right,left} order of held.
    assign raw_vec = {bus.pbr_raw, bus.pbl_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic             s1_q;
            logic             s2_q;
            logic [1:0]       state_q;
            logic [1:0]       state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             pulse_q;
            logic             pulse_d;
            logic             held_q;
            logic             held_d;

            // The counter restarts at zero on every state change, so it only ever
            // measures how long s2 has disagreed with the accepted level. It never
            // wraps because reaching CNT_LAST always forces a state exit.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                pulse_d = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (s2_q) begin
                            state_d = ST_PRESS_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!s2_q) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = ST_HELD;
                            cnt_d   = '0;
                            pulse_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!s2_q) begin
                            state_d = ST_RELEASE_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (s2_q) begin
                            // Bounce during release: back to HELD with no new pulse.
                            state_d = ST_HELD;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
                // held follows the next state so it rises on the same edge as the pulse.
                held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
            end

            always_ff @(posedge CLK_I or posedge rst) begin
                if (rst) begin
                    s1_q    <= 1'b0;
                    s2_q    <= 1'b0;
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    pulse_q <= 1'b0;
                    held_q  <= 1'b0;
                end else begin
                    s1_q    <= raw_vec[gi];
                    s2_q    <= s1_q;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    pulse_q <= pulse_d;
                    held_q  <= held_d;
                end
            end

            assign pulse_vec[gi] = pulse_q;
            assign held_vec[gi]  = held_q;
        end
    endgenerate

    assign bus.pbl  = pulse_vec[0];
    assign bus.pbr  = pulse_vec[1];
    assign bus.held = held_vec;

endmodule

// File: tb/tb_pb_conditioner.sv
// tb_pb_conditioner
//   Directed scenarios (reset, clean press, bounce, release bounce, simultaneous
//   presses, reset mid-debounce and mid-pulse) followed by randomized button
//   activity. A run-length reference model predicts pulses and held every cycle.
module tb_pb_conditioner;

    localparam int D = 4;

    logic clk;
    logic rst;

    pb_conditioner_if bus ();

    pb_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(16)
    ) dut (
        .CLK_I(clk),
        .rst  (rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a press (release) is accepted once the synchronized level has
    // disagreed with the accepted level on D+1 consecutive clock edges; any agreeing
    // sample resets the run. Accepting a press produces the pulse.
    bit [1:0] m_s1, m_s2, m_acc, m_pulse;
    int       m_run [2];
    int       edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_acc = '0; m_pulse = '0;
            m_run[0] = 0; m_run[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_pulse[i] = 1'b0;
                if (m_s2[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_acc[i]   = m_s2[i];
                        m_run[i]   = 0;
                        m_pulse[i] = m_s2[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {bus.pbr_raw, bus.pbl_raw};
        end
    end

    // Per-cycle comparison against the model plus pulse bookkeeping for the
    // directed scenarios.
    int cnt_l = 0, cnt_r = 0, cnt_both = 0;
    int last_l_edge = -1, last_r_edge = -1;

    always @(posedge clk) begin
        #1;
        check("pbl", int'(bus.pbl), int'(m_pulse[0]));
        check("pbr", int'(bus.pbr), int'(m_pulse[1]));
        check("held", int'(bus.held), int'(m_acc));
        if (bus.pbl === 1'b1) begin cnt_l++; last_l_edge = edge_cnt; end
        if (bus.pbr === 1'b1) begin cnt_r++; last_r_edge = edge_cnt; end
        if (bus.pbl === 1'b1 && bus.pbr === 1'b1) cnt_both++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int k, c_l, c_r, c_b;
    int rem [2];
    bit got_pulse;

    initial begin
        rst = 1'b0;
        bus.pbl_raw = 1'b1;
        bus.pbr_raw = 1'b1;
        #1 rst = 1'b1;
        #1;
        // Async reset takes effect before any clock edge.
        check("rst_pbl_noclk", int'(bus.pbl), 0);
        check("rst_pbr_noclk", int'(bus.pbr), 0);
        check("rst_held_noclk", int'(bus.held), 0);
        tick(3);
        check("rst_held_clk", int'(bus.held), 0);
        check("rst_pbl_clk", int'(bus.pbl), 0);
        bus.pbl_raw = 1'b0;
        bus.pbr_raw = 1'b0;
        rst = 1'b0;
        tick(4);

        // Clean left press held for 20 cycles.
        c_l = cnt_l; c_r = cnt_r;
        k = edge_cnt + 1;
        bus.pbl_raw = 1'b1;
        tick(20);
        check("clean_cnt", cnt_l - c_l, 1);
        check("clean_edge", last_l_edge, k + 2 + D);
        check("clean_pbr", cnt_r - c_r, 0);
        check("clean_held", int'(bus.held), 1);
        bus.pbl_raw = 1'b0;
        tick(10);

        // Right button bouncing 1,0,1,0 then steady 1.
        c_r = cnt_r;
        bus.pbr_raw = 1'b1; tick(1);
        bus.pbr_raw = 1'b0; tick(1);
        bus.pbr_raw = 1'b1; tick(1);
        bus.pbr_raw = 1'b0; tick(1);
        k = edge_cnt + 1;
        bus.pbr_raw = 1'b1;
        tick(20);
        check("bounce_cnt", cnt_r - c_r, 1);
        check("bounce_edge", last_r_edge, k + 2 + D);
        bus.pbr_raw = 1'b0;
        tick(10);

        // Release bounce while held, then a proper release and a second press.
        c_l = cnt_l;
        bus.pbl_raw = 1'b1; tick(12);
        bus.pbl_raw = 1'b0; tick(2);
        bus.pbl_raw = 1'b1; tick(10);
        check("relbounce_cnt", cnt_l - c_l, 1);
        check("relbounce_held", int'(bus.held), 1);
        bus.pbl_raw = 1'b0; tick(10);
        check("released_held", int'(bus.held), 0);
        bus.pbl_raw = 1'b1; tick(12);
        check("second_press_cnt", cnt_l - c_l, 2);
        bus.pbl_raw = 1'b0; tick(10);

        // Simultaneous presses.
        c_b = cnt_both;
        bus.pbl_raw = 1'b1; bus.pbr_raw = 1'b1;
        tick(12);
        check("simul_both", cnt_both - c_b, 1);
        check("simul_same_edge", last_l_edge, last_r_edge);
        check("simul_held", int'(bus.held), 3);
        bus.pbl_raw = 1'b0; bus.pbr_raw = 1'b0;
        tick(10);

        // Reset while the left counter is at 2, button still held afterwards.
        c_l = cnt_l;
        bus.pbl_raw = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(1);
        check("rstmid_no_pulse", cnt_l - c_l, 0);
        k = edge_cnt + 1;
        rst = 1'b0;
        tick(12);
        check("rstmid_cnt", cnt_l - c_l, 1);
        check("rstmid_edge", last_l_edge, k + 2 + D);
        bus.pbl_raw = 1'b0;
        tick(10);

        // Reset asserted while a pulse is high: outputs drop without a clock edge.
        bus.pbr_raw = 1'b1;
        got_pulse = 1'b0;
        for (int i = 0; i < 20 && !got_pulse; i++) begin
            @(posedge clk);
            #2;
            if (bus.pbr === 1'b1) got_pulse = 1'b1;
        end
        check("midpulse_seen", int'(got_pulse), 1);
        rst = 1'b1;
        #1;
        check("midpulse_pbr", int'(bus.pbr), 0);
        check("midpulse_held", int'(bus.held), 0);
        @(negedge clk);
        bus.pbr_raw = 1'b0;
        rst = 1'b0;
        tick(10);

        // Randomized bouncing buttons with occasional resets.
        rem[0] = 1; rem[1] = 1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rem[i] == 0) begin
                    if (i == 0) bus.pbl_raw = ~bus.pbl_raw;
                    else        bus.pbr_raw = ~bus.pbr_raw;
                    rem[i] = (($urandom_range(0, 3) == 0) ? $urandom_range(6, 15)
                                                          : $urandom_range(0, 6));
                end else begin
                    rem[i]--;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
